scr1_imem_dmem_arb: RTL

Two-to-one memory arbiter that shares a single core-side memory port between the instruction-fetch (imem) and load/store (dmem) request interfaces, using the SCR1 req/req_ack/resp protocol. Grants round-robin on conflict, locks the grant until acceptance, and tracks up to OUTST_DEPTH accepted-but-unanswered transactions in an in-order ID FIFO so each response returns to the correct requester. Sits between the core and the AHB/AXI bridge, so one bridge serves both streams.

---
 rtl/scr1_arb_pkg.sv | 27 ++
 rtl/scr1_imem_dmem_arb_if.sv | 50 +++++
 rtl/scr1_arb_id_fifo.sv | 73 +++++++
 rtl/scr1_imem_dmem_arb.sv | 127 ++++++++++++
 4 files changed

// File: rtl/scr1_arb_pkg.sv
// Shared types for the SCR1 imem/dmem memory arbiter: response, command,
// access width and requester-ID encodings.
package scr1_arb_pkg;

   typedef enum logic [1:0] {
      ARB_RESP_IDLE = 2'b00,
      ARB_RESP_RDY  = 2'b01,
      ARB_RESP_ER   = 2'b10
   } arb_resp_e;

   typedef enum logic {
      ARB_CMD_RD = 1'b0,
      ARB_CMD_WR = 1'b1
   } arb_cmd_e;

   typedef enum logic [1:0] {
      ARB_WIDTH_BYTE  = 2'b00,
      ARB_WIDTH_HWORD = 2'b01,
      ARB_WIDTH_WORD  = 2'b10
   } arb_width_e;

   typedef enum logic {
      ARB_SRC_IMEM = 1'b0,
      ARB_SRC_DMEM = 1'b1
   } arb_src_e;

endpackage

// File: rtl/scr1_imem_dmem_arb_if.sv
// Bundle of the three SCR1 req/req_ack/resp ports around the arbiter:
// imem and dmem requesters on the core side, one shared port to the bridge.
interface scr1_imem_dmem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_req_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic [1:0]        imem_resp;

   logic              dmem_req;
   logic              dmem_cmd;
   logic [1:0]        dmem_width;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_req_ack;
   logic [DATA_W-1:0] dmem_rdata;
   logic [1:0]        dmem_resp;

   logic              mem_req;
   logic              mem_cmd;
   logic [1:0]        mem_width;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_req_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic [1:0]        mem_resp;

   // Arbiter view.
   modport slave (
      input  imem_req, imem_addr,
      output imem_req_ack, imem_rdata, imem_resp,
      input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      output dmem_req_ack, dmem_rdata, dmem_resp,
      output mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
      input  mem_req_ack, mem_rdata, mem_resp
   );

   // Environment view: core requesters plus bridge.
   modport master (
      output imem_req, imem_addr,
      input  imem_req_ack, imem_rdata, imem_resp,
      output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      input  dmem_req_ack, dmem_rdata, dmem_resp,
      input  mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
      output mem_req_ack, mem_rdata, mem_resp
   );
endinterface

// File: rtl/scr1_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted transactions still awaiting
// a response; the head names the owner of the next response.
module scr1_arb_id_fifo
   import scr1_arb_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  arb_src_e         push_id,
   input  logic             pop,
   output arb_src_e         head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_id;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: ID storage is not reset; an entry is only read after it was written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = arb_src_e'(mem_q[rd_ptr_q]);
   assign count = cnt_q;
   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/scr1_imem_dmem_arb.sv
// Two-to-one SCR1 memory arbiter: round-robin grant with lock-until-accept,
// in-order response routing through an outstanding-ID FIFO.
module scr1_imem_dmem_arb
   import scr1_arb_pkg::*;
#(
   parameter int OUTST_DEPTH = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   scr1_imem_dmem_arb_if.slave   arb_if,
   output logic                  arb_err
);

   localparam int CNT_W = $clog2(OUTST_DEPTH + 1);

   logic [CNT_W-1:0]  cnt;
   logic              full, empty;
   arb_src_e          head_id;

   logic              lock_q, lock_d;
   arb_src_e          lock_src_q, lock_src_d;
   logic              last_dmem_q, last_dmem_d;
   logic              arb_err_q, arb_err_d;

   arb_src_e          grant;
   logic              imem_elig, dmem_elig;
   logic              mem_req_int, accept, resp_vld, pop;
   logic              sel_cmd;
   logic [1:0]        sel_width;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // A full ID FIFO blocks new grants; a lock can only exist below full.
   always_comb begin
      imem_elig   = arb_if.imem_req & ~full;
      dmem_elig   = arb_if.dmem_req & ~full;
      if (lock_q) begin
         grant = lock_src_q;
      end else if (imem_elig & dmem_elig) begin
         grant = last_dmem_q ? ARB_SRC_IMEM : ARB_SRC_DMEM;
      end else if (dmem_elig) begin
         grant = ARB_SRC_DMEM;
      end else begin
         grant = ARB_SRC_IMEM;
      end
      mem_req_int = lock_q | imem_elig | dmem_elig;
      accept      = mem_req_int & arb_if.mem_req_ack;
   end

   always_comb begin
      if (grant == ARB_SRC_DMEM) begin
         sel_cmd   = arb_if.dmem_cmd;
         sel_width = arb_if.dmem_width;
         sel_addr  = arb_if.dmem_addr;
         sel_wdata = arb_if.dmem_wdata;
      end else begin
         sel_cmd   = ARB_CMD_RD;
         sel_width = ARB_WIDTH_WORD;
         sel_addr  = arb_if.imem_addr;
         sel_wdata = '0;
      end
   end

   assign arb_if.mem_req      = mem_req_int;
   assign arb_if.mem_cmd      = sel_cmd;
   assign arb_if.mem_width    = sel_width;
   assign arb_if.mem_addr     = sel_addr;
   assign arb_if.mem_wdata    = sel_wdata;
   assign arb_if.imem_req_ack = accept & (grant == ARB_SRC_IMEM);
   assign arb_if.dmem_req_ack = accept & (grant == ARB_SRC_DMEM);

   // Responses with nothing outstanding are dropped and flagged, never routed.
   assign resp_vld = (arb_if.mem_resp != ARB_RESP_IDLE);
   assign pop      = resp_vld & ~empty;

   assign arb_if.imem_resp  = (pop && head_id == ARB_SRC_IMEM) ? arb_if.mem_resp : ARB_RESP_IDLE;
   assign arb_if.dmem_resp  = (pop && head_id == ARB_SRC_DMEM) ? arb_if.mem_resp : ARB_RESP_IDLE;
   assign arb_if.imem_rdata = arb_if.mem_rdata;
   assign arb_if.dmem_rdata = arb_if.mem_rdata;

   always_comb begin
      lock_d      = lock_q;
      lock_src_d  = lock_src_q;
      last_dmem_d = last_dmem_q;
      arb_err_d   = arb_err_q | (resp_vld & (cnt == '0));
      if (accept) begin
         lock_d      = 1'b0;
         last_dmem_d = (grant == ARB_SRC_DMEM);
      end else if (mem_req_int) begin
         lock_d     = 1'b1;
         lock_src_d = grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q      <= 1'b0;
         lock_src_q  <= ARB_SRC_IMEM;
         last_dmem_q <= 1'b0;
         arb_err_q   <= 1'b0;
      end else begin
         lock_q      <= lock_d;
         lock_src_q  <= lock_src_d;
         last_dmem_q <= last_dmem_d;
         arb_err_q   <= arb_err_d;
      end
   end

   assign arb_err = arb_err_q;

   scr1_arb_id_fifo #(
      .DEPTH (OUTST_DEPTH)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (accept),
      .push_id (grant),
      .pop     (pop),
      .head    (head_id),
      .count   (cnt),
      .full    (full),
      .empty   (empty)
   );

endmodule
